// File: rtl/fixedpointscaler_ctrl.sv
// Sequencer for the fixedpointscaler datapath. It feeds accepted MVP words and per-channel
// coefficients into the scaler, tracks its 3-cycle pipe and limits input with credits.
module fixedpointscaler_ctrl #(
  parameter int unsigned BA      = 27,
  parameter int unsigned BB      = 16,
  parameter int unsigned BC      = 27,
  parameter int unsigned NCH     = 16,
  parameter int unsigned LW      = 16,
  parameter int unsigned CREDITS = 4,
  localparam int unsigned CW     = $clog2(NCH),
  localparam int unsigned KW     = $clog2(CREDITS + 1)
) (
  input  logic          clk,
  input  logic          clr_n,
  input  logic          cfg_we,
  input  logic [CW-1:0] cfg_addr,
  input  logic [BB-1:0] cfg_scale,
  input  logic [BC-1:0] cfg_bias,
  input  logic [BA-1:0] cfg_offset,
  input  logic [CW:0]   cfg_nch,
  input  logic          start,
  input  logic [LW-1:0] job_len,
  input  logic          abort,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [BA-1:0] in_data,
  output logic          sc_clr,
  output logic [BA-1:0] sc_a,
  output logic [BA-1:0] sc_d,
  output logic [BB-1:0] sc_b,
  output logic [BC-1:0] sc_c,
  output logic          out_valid,
  output logic [CW-1:0] out_chan,
  input  logic          credit_return,
  output logic          busy,
  output logic          done
);

  localparam int unsigned NW  = CW + 1;
  localparam int unsigned PIPE = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e                    state_q, state_d;
  logic [LW-1:0]             rem_q, rem_d;
  logic [NW-1:0]             nch_q, nch_d;
  logic [CW-1:0]             chan_q, chan_d;
  logic [KW-1:0]             cred_q, cred_d;
  logic                      zl_q, zl_d;
  logic                      done_q, done_d;
  logic [PIPE-1:0]           vld_q;
  logic [PIPE-1:0][CW-1:0]   pch_q;

  logic [BA-1:0] off_mem   [NCH];
  logic [BB-1:0] scale_mem [NCH];
  logic [BC-1:0] bias_mem  [NCH];

  logic          acc;
  logic          chan_last;
  logic [CW-1:0] chan_in;

  assign in_ready  = (state_q == RUN) && (rem_q != '0) && (cred_q != '0) && !abort;
  assign acc       = in_valid && in_ready;
  assign chan_last = (NW'(chan_q) + NW'(1)) == nch_q;
  assign chan_in   = acc ? chan_q : '0;

  // Coefficient table; only software in IDLE may change it, never reset
  always_ff @(posedge clk) begin
    if (cfg_we && (state_q == IDLE)) begin
      off_mem[cfg_addr]   <= cfg_offset;
      scale_mem[cfg_addr] <= cfg_scale;
      bias_mem[cfg_addr]  <= cfg_bias;
    end
  end

  // Scaler operands are live only in the accept cycle
  always_comb begin
    sc_a = '0;
    sc_d = '0;
    sc_b = '0;
    sc_c = '0;
    if (acc) begin
      sc_a = in_data;
      sc_d = off_mem[chan_q];
      sc_b = scale_mem[chan_q];
      sc_c = bias_mem[chan_q];
    end
  end

  assign sc_clr = !clr_n || abort;

  // Next-state logic: sequencing, credit accounting and completion
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    nch_d   = nch_q;
    chan_d  = chan_q;
    cred_d  = cred_q;
    zl_d    = zl_q;
    done_d  = 1'b0;

    if (acc && !credit_return) begin
      cred_d = cred_q - KW'(1);
    end else if (!acc && credit_return && (cred_q != KW'(CREDITS))) begin
      cred_d = cred_q + KW'(1);
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          rem_d  = job_len;
          nch_d  = (cfg_nch == '0) ? NW'(NCH) : cfg_nch;
          chan_d = '0;
          if (job_len == '0) begin
            state_d = DRAIN;
            zl_d    = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (acc) begin
          rem_d  = rem_q - LW'(1);
          chan_d = chan_last ? '0 : chan_q + CW'(1);
          if (rem_q == LW'(1)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        // A zero-length job still reports done one cycle into DRAIN
        if (zl_q) begin
          zl_d   = 1'b0;
          done_d = 1'b1;
        end else begin
          done_d = vld_q[1] && !vld_q[0];
          if (!vld_q[0] && !vld_q[1]) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (abort) begin
      state_d = IDLE;
      zl_d    = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      nch_q   <= '0;
      chan_q  <= '0;
      cred_q  <= KW'(CREDITS);
      zl_q    <= 1'b0;
      done_q  <= 1'b0;
      vld_q   <= '0;
      pch_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      nch_q   <= nch_d;
      chan_q  <= chan_d;
      cred_q  <= cred_d;
      zl_q    <= zl_d;
      done_q  <= done_d;
      if (abort) begin
        vld_q <= '0;
        pch_q <= '0;
      end else begin
        vld_q <= {vld_q[PIPE-2:0], acc};
        pch_q <= {pch_q[PIPE-2:0], chan_in};
      end
    end
  end

  assign out_valid = vld_q[PIPE-1];
  assign out_chan  = pch_q[PIPE-1];
  assign done      = done_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_fixedpointscaler_ctrl.sv
// Directed bench for fixedpointscaler_ctrl: basic job, credit stall, zero length,
// abort, reset in DRAIN, config lockout and full-table channel wrap.
module tb_fixedpointscaler_ctrl;

  localparam int unsigned BA  = 27;
  localparam int unsigned BB  = 16;
  localparam int unsigned BC  = 27;
  localparam int unsigned NCH = 16;
  localparam int unsigned CW  = 4;
  localparam int unsigned LW  = 16;

  logic          clk;
  logic          clr_n;
  logic          cfg_we;
  logic [CW-1:0] cfg_addr;
  logic [BB-1:0] cfg_scale;
  logic [BC-1:0] cfg_bias;
  logic [BA-1:0] cfg_offset;
  logic [CW:0]   cfg_nch;
  logic          start;
  logic [LW-1:0] job_len;
  logic          abort;
  logic          in_valid;
  logic          in_ready;
  logic [BA-1:0] in_data;
  logic          sc_clr;
  logic [BA-1:0] sc_a;
  logic [BA-1:0] sc_d;
  logic [BB-1:0] sc_b;
  logic [BC-1:0] sc_c;
  logic          out_valid;
  logic [CW-1:0] out_chan;
  logic          credit_return;
  logic          busy;
  logic          done;

  int n_chk  = 0;
  int n_fail = 0;
  int n_acc;
  bit idle;
  longint exp_p [3] = '{20, 12, 6};

  fixedpointscaler_ctrl dut (
    .clk           (clk),
    .clr_n         (clr_n),
    .cfg_we        (cfg_we),
    .cfg_addr      (cfg_addr),
    .cfg_scale     (cfg_scale),
    .cfg_bias      (cfg_bias),
    .cfg_offset    (cfg_offset),
    .cfg_nch       (cfg_nch),
    .start         (start),
    .job_len       (job_len),
    .abort         (abort),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .sc_clr        (sc_clr),
    .sc_a          (sc_a),
    .sc_d          (sc_d),
    .sc_b          (sc_b),
    .sc_c          (sc_c),
    .out_valid     (out_valid),
    .out_chan      (out_chan),
    .credit_return (credit_return),
    .busy          (busy),
    .done          (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_row(input int a, input int off, input int scl, input int bias);
    cfg_we     = 1'b1;
    cfg_addr   = CW'(a);
    cfg_offset = BA'(off);
    cfg_scale  = BB'(scl);
    cfg_bias   = BC'(bias);
    cyc();
    cfg_we     = 1'b0;
  endtask

  // Scaler result the current operands would produce: (a + d) * b + c
  function automatic longint pval();
    longint a, d, b, c;
    a = longint'($signed(sc_a));
    d = longint'($signed(sc_d));
    b = longint'(sc_b);
    c = longint'($signed(sc_c));
    return (a + d) * b + c;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clr_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_scale = '0; cfg_bias = '0;
    cfg_offset = '0; cfg_nch = '0; start = 1'b0; job_len = '0; abort = 1'b0;
    in_valid = 1'b0; in_data = '0; credit_return = 1'b0;

    // Reset values
    #7;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_sc_clr", sc_clr, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_chan", out_chan, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sc_a", sc_a, 0);
    #5 clr_n = 1'b1;
    cyc();
    chk("sc_clr_idle", sc_clr, 0);

    wr_row(0, 1, 2, 10);
    wr_row(1, 0, 3, 0);
    wr_row(2, -5, 1, 7);
    for (int r = 3; r < 16; r++) wr_row(r, 0, 1, 0);

    // Basic job, nch=3, six words of 4
    cfg_nch = 5'd3; job_len = 16'd6; credit_return = 1'b1; in_data = 27'd4;
    start = 1'b1; cyc(); start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      in_valid = (k < 6);
      #1;
      if (k < 6) begin
        chk("basic_ready", in_ready, 1);
        chk("basic_p", pval(), exp_p[k % 3]);
      end
      chk("basic_ov", out_valid, (k >= 3 && k <= 8));
      if (k >= 3 && k <= 8) chk("basic_chan", out_chan, (k - 3) % 3);
      chk("basic_done", done, (k == 8));
      chk("basic_busy", busy, (k <= 8));
      cyc();
    end

    // Credit stall: four accepts then blocked
    credit_return = 1'b0; job_len = 16'd8;
    start = 1'b1; cyc(); start = 1'b0;
    in_valid = 1'b1; n_acc = 0;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (in_ready) n_acc++;
      cyc();
    end
    chk("stall_acc", n_acc, 4);
    credit_return = 1'b1;
    #1; chk("ret1_ready", in_ready, 0); cyc();
    #1; chk("ret2_ready", in_ready, 1); cyc();
    credit_return = 1'b0;
    #1; chk("ret3_ready", in_ready, 1); cyc();
    #1; chk("ret4_ready", in_ready, 0); cyc();
    n_acc = 6;
    credit_return = 1'b1; idle = 1'b0;
    for (int k = 0; k < 20 && !idle; k++) begin
      #1;
      if (in_valid && in_ready) n_acc++;
      idle = !busy;
      cyc();
    end
    chk("stall_idle", idle, 1);
    chk("stall_total", n_acc, 8);
    in_valid = 1'b0;
    repeat (6) cyc();

    // Zero-length job
    job_len = 16'd0;
    start = 1'b1; cyc(); start = 1'b0;
    #1; chk("zl_busy1", busy, 1); chk("zl_done1", done, 0); cyc();
    #1; chk("zl_busy2", busy, 1); chk("zl_done2", done, 1); chk("zl_ov", out_valid, 0); cyc();
    #1; chk("zl_busy3", busy, 0); chk("zl_done3", done, 0); cyc();

    // Abort after three of ten accepts
    cfg_nch = 5'd3; job_len = 16'd10; in_data = 27'd4;
    start = 1'b1; cyc(); start = 1'b0;
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1; chk("ab_acc_ready", in_ready, 1); cyc();
    end
    abort = 1'b1;
    #1; chk("ab_clr", sc_clr, 1); chk("ab_ready", in_ready, 0); cyc();
    abort = 1'b0; in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("ab_busy", busy, 0);
      chk("ab_ov", out_valid, 0);
      chk("ab_done", done, 0);
      chk("ab_clr_off", sc_clr, 0);
      cyc();
    end
    job_len = 16'd2;
    start = 1'b1; cyc(); start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      in_valid = (k < 2);
      #1;
      if (k < 2) chk("nj_p", pval(), exp_p[k]);
      chk("nj_ov", out_valid, (k == 3 || k == 4));
      if (k == 3 || k == 4) chk("nj_chan", out_chan, k - 3);
      chk("nj_done", done, (k == 4));
      cyc();
    end

    // Reset while draining restores credits
    credit_return = 1'b0; job_len = 16'd4;
    start = 1'b1; cyc(); start = 1'b0;
    in_valid = 1'b1;
    repeat (4) cyc();
    in_valid = 1'b0;
    #1; chk("rd_busy_pre", busy, 1);
    #1 clr_n = 1'b0;
    #1;
    chk("rd_busy", busy, 0);
    chk("rd_ov", out_valid, 0);
    chk("rd_done", done, 0);
    chk("rd_clr", sc_clr, 1);
    chk("rd_ready", in_ready, 0);
    chk("rd_chan", out_chan, 0);
    #2 clr_n = 1'b1;
    cyc();
    job_len = 16'd8;
    start = 1'b1; cyc(); start = 1'b0;
    in_valid = 1'b1; n_acc = 0;
    for (int k = 0; k < 7; k++) begin
      #1;
      if (in_ready) n_acc++;
      cyc();
    end
    chk("rd_credits", n_acc, 4);
    abort = 1'b1; cyc(); abort = 1'b0; in_valid = 1'b0;
    credit_return = 1'b1;
    repeat (6) cyc();

    // cfg_nch=0 uses the full table; a write during RUN is dropped
    cfg_nch = 5'd0; job_len = 16'd17;
    start = 1'b1; cyc(); start = 1'b0;
    for (int k = 0; k < 21; k++) begin
      in_valid   = (k < 17);
      cfg_we     = (k == 1);
      cfg_addr   = '0;
      cfg_scale  = 16'd99;
      cfg_offset = '0;
      cfg_bias   = '0;
      #1;
      if (k == 0 || k == 16) chk("lk_scale", sc_b, 2);
      if (k < 17) chk("w_ready", in_ready, 1);
      chk("w_ov", out_valid, (k >= 3 && k <= 19));
      if (k >= 3 && k <= 19) chk("w_chan", out_chan, (k - 3) % 16);
      chk("w_done", done, (k == 19));
      chk("w_busy", busy, (k <= 19));
      cyc();
    end
    cfg_we = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fixedpointscaler_ctrl.md
# fixedpointscaler_ctrl

Sequencer for the `fixedpointscaler` datapath. It accepts MVP result words over a valid/ready stream and drives them into the scaler's `a` input. For each word it supplies the per-output-channel pre-add offset (`d`), scale (`b`) and bias (`c`) from an internal table, tracks the scaler's fixed 3-cycle pipeline with a valid/channel shift register, and rate-limits input with credits, because the scaler cannot stall.

## Interface
- `BA`, 27: MVP result / scaler `a` and offset `d` width
- `BB`, 16: scale width
- `BC`, 27: bias width
- `NCH`, 16: channel table depth; `CW = $clog2(NCH)`
- `LW`, 16: job-length counter width
- `CREDITS`, 4: downstream buffer slots; `KW = $clog2(CREDITS+1)`
- `clk`  in  1  clock, all logic on rising edge
- `clr_n`  in  1  reset, asynchronous, active-low
- `cfg_we`  in  1  table write strobe; ignored unless state is IDLE
- `cfg_addr`  in  CW  table row
- `cfg_scale`, `cfg_bias`, `cfg_offset`  in  BB / BC / BA  row contents
- `cfg_nch`  in  CW+1  active channels; 0 means NCH; sampled on start
- `start`  in  1  begin job; honoured only in IDLE
- `job_len`  in  LW  words in job; sampled on start
- `abort`  in  1  cancel job, any state
- `in_valid`  in  1  MVP word present
- `in_ready`  out  1  word accepted when `in_valid && in_ready`
- `in_data`  in  BA  MVP word
- `sc_clr`  out  1  to scaler `clr`
- `sc_a`, `sc_d`  out  BA  to scaler `a`, `d`
- `sc_b`  out  BB  to scaler `b`
- `sc_c`  out  BC  to scaler `c`
- `out_valid`  out  1  scaler `p` is valid this cycle
- `out_chan`  out  CW  channel index of the current `p`
- `credit_return`  in  1  downstream freed one slot
- `busy`  out  1  state is not IDLE
- `done`  out  1  one-cycle pulse when the last result is valid

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE -> RUN on `start`. On that edge: latch `rem = job_len`, `nch = (cfg_nch==0 ? NCH : cfg_nch)`, `chan = 0`.
- If `start` arrives with `job_len == 0`, go IDLE -> DRAIN instead. `done` then fires one cycle later with no output.
- `in_ready = (state==RUN) && rem != 0 && credits != 0 && !abort`.
- On each accept:
  - `sc_a = in_data`; `sc_d`, `sc_b`, `sc_c` = table[`chan`], all combinational in the same cycle.
  - `rem` decrements.
  - `chan` increments and wraps to 0 after `nch-1`.
  - `credits` decrements.
- On non-accept cycles, `sc_a`, `sc_b`, `sc_c` and `sc_d` are driven to 0.
- Valid pipe: a 3-stage shift of {accept, chan}. `out_valid` and `out_chan` are stage 3.
- RUN -> DRAIN on the accept that makes `rem` reach 0.
- DRAIN -> IDLE when the valid pipe is empty. `done` pulses in the cycle the final `out_valid` is high, or one cycle after entering DRAIN for a zero-length job.
- Credits: reset value is CREDITS. An accept and a `credit_return` in the same cycle leave the count unchanged.
  - `credit_return` at the CREDITS ceiling saturates.
  - Credits are not reset by `start` or `abort`.
- `abort`: next state IDLE, and `sc_clr = 1` for that cycle. The valid pipe is flushed and there is no `done`.
- `sc_clr` is also high while `clr_n` is low.
- `cfg_we` writes while not in IDLE are dropped. `start` while busy is ignored.
- Table contents are not reset; the power-on value is undefined and software writes every row used.

## Timing
- Reset values: `in_ready=0`, `sc_a/b/c/d=0`, `sc_clr=1` (during reset), `out_valid=0`, `out_chan=0`, `done=0`, `busy=0`. State is IDLE, credits are CREDITS.
- The scaler registers `a+d` and `b` at edge 1, the product at edge 2, and `+c` at edge 3.
- Latency rule: a word accepted in cycle t has `out_valid` at cycle t+3.
- Throughput: 1 word/cycle while credits are available.
- `start` edge -> `in_ready` can be high the next cycle.
- Last accept at t -> `done` and `busy` deassert: `done` at t+3, `busy` low at t+4.
- Table write to the current row during IDLE is visible to the first accept of the next job.

## Test plan
- Basic job:
  - Setup: `nch=3`; rows 0/1/2 = {offset 1, scale 2, bias 10} / {0, 3, 0} / {−5, 1, 7}; `job_len=6`; `in_data` = 4,4,4,4,4,4; `credit_return` tied high.
  - Required: `p` = 20, 12, 6, 20, 12, 6; `out_chan` = 0,1,2,0,1,2.
  - Required: first `out_valid` 3 cycles after the first accept; `done` with the 6th result.
- Credit stall:
  - Setup: `CREDITS=4`, no `credit_return`, `job_len=8`.
  - Required: exactly 4 accepts, then `in_ready=0`.
  - Then: 2 returns -> 2 more accepts. A return and an accept in the same cycle keep the count constant.
- Zero length: `start` with `job_len=0` -> `done` 2 cycles after `start`; no `out_valid`; `busy` for 2 cycles.
- Abort mid-job: abort after 3 of 10 accepts -> `sc_clr` for 1 cycle, no further `out_valid`, no `done`, IDLE next cycle, a new job runs correctly.
- Reset mid-DRAIN: assert `clr_n=0` asynchronously -> all outputs at reset values immediately, credits restored to CREDITS.
- Config lockout and `cfg_nch=0`:
  - A `cfg_we` during RUN leaves the row unchanged.
  - A job with `cfg_nch=0` and `job_len=17` shows `out_chan` wrapping 15 -> 0.
